// File: rtl/imem_loader_ctrl.sv
// ---------------------------------------------------------------------------
// imem_loader_ctrl
//
// Downloads a program into the instruction RAM through the RAM's debug port.
// Bytes arrive on a valid/ready stream and are packed little-endian into
// 32-bit words. Each word is written to BASE_ADDR + 4*index. The CPU core is
// held for the whole load. The block reports completion, a length error and,
// in the verify build, the first read-back mismatch.
//
// Build option:
//   IMEM_LOAD_VERIFY_EN - when defined, every written word is read back
//                         through the debug port and compared. The first
//                         mismatch aborts the load. When undefined, err_verify
//                         and err_addr are tied to 0 and dbg_rdata is unused.
//
// Ports:
//   clk, rst_n  - clock; asynchronous active-low reset
//   start       - begin a load (sampled only in IDLE)
//   len_words   - number of words to load, latched on start
//   byte_in     - stream byte
//   byte_valid  - stream byte is valid
//   byte_ready  - controller accepts the stream byte
//   dbg_addr    - byte address to the debug port
//   dbg_wdata   - write data to the debug port
//   dbg_we      - byte write enables to the debug port
//   dbg_rdata   - read data from the debug port (one cycle after address)
//   cpu_hold    - hold request to the CPU core during a load
//   busy        - load in progress
//   done        - one-cycle pulse at the end of every load
//   err_len     - sticky: len_words exceeded DEPTH_WORDS
//   err_verify  - sticky: read-back mismatch
//   err_addr    - byte address of the first mismatch
// ---------------------------------------------------------------------------
module imem_loader_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LEN_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [31:0]      dbg_addr,
   output logic [31:0]      dbg_wdata,
   output logic [3:0]       dbg_we,
   input  logic [31:0]      dbg_rdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err_len,
   output logic             err_verify,
   output logic [31:0]      err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_RDA,
      S_RDC,
      S_NEXT,
      S_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [31:0]      word_q, word_d;
   logic [31:0]      addr_q, addr_d;
   logic             err_len_q, err_len_d;

`ifdef IMEM_LOAD_VERIFY_EN
   logic             err_verify_q, err_verify_d;
   logic [31:0]      err_addr_q, err_addr_d;
`else
   logic             unused_rdata;
   assign unused_rdata = ^dbg_rdata;
`endif

   // State and datapath registers. On reset, everything returns to zero.
   // This drops the hold and stops any write immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         byte_cnt_q   <= '0;
         word_q       <= '0;
         addr_q       <= '0;
         err_len_q    <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
         err_verify_q <= 1'b0;
         err_addr_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         addr_q       <= addr_d;
         err_len_q    <= err_len_d;
`ifdef IMEM_LOAD_VERIFY_EN
         err_verify_q <= err_verify_d;
         err_addr_q   <= err_addr_d;
`endif
      end
   end

   // Next-state and datapath updates.
   // The write address is computed when leaving RECV, so dbg_addr comes
   // straight from a register. It holds between words.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      idx_d        = idx_q;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      addr_d       = addr_q;
      err_len_d    = err_len_q;
`ifdef IMEM_LOAD_VERIFY_EN
      err_verify_d = err_verify_q;
      err_addr_d   = err_addr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d      = len_words;
               idx_d      = '0;
               byte_cnt_d = '0;
               word_d     = '0;
               err_len_d  = 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
               err_verify_d = 1'b0;
               err_addr_d   = '0;
`endif
               if (32'(len_words) > DEPTH_WORDS) begin
                  err_len_d = 1'b1;
                  state_d   = S_FIN;
               end else if (len_words == '0) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (byte_valid) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
`ifdef IMEM_LOAD_VERIFY_EN
            state_d = S_RDA;
`else
            state_d = S_NEXT;
`endif
         end

`ifdef IMEM_LOAD_VERIFY_EN
         // The RAM is synchronous. The address presented in RDA returns its
         // data in RDC.
         S_RDA: begin
            state_d = S_RDC;
         end

         S_RDC: begin
            if (dbg_rdata != word_q) begin
               err_verify_d = 1'b1;
               err_addr_d   = addr_q;
               state_d      = S_FIN;
            end else begin
               state_d = S_NEXT;
            end
         end
`endif

         // The index cannot overflow because len_words <= DEPTH_WORDS was
         // checked at start.
         S_NEXT: begin
            idx_d = idx_q + LEN_W'(1);
            if ((idx_q + LEN_W'(1)) == len_q) begin
               state_d = S_FIN;
            end else begin
               state_d = S_RECV;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the state alone, so an asynchronous reset
   // clears them at once.
   always_comb begin
      byte_ready = (state_q == S_RECV);
      dbg_we     = (state_q == S_WRITE) ? 4'hF : 4'h0;
      busy       = (state_q == S_RECV) || (state_q == S_WRITE) ||
                   (state_q == S_RDA)  || (state_q == S_RDC)   ||
                   (state_q == S_NEXT);
      cpu_hold   = busy;
      done       = (state_q == S_FIN);
   end

   assign dbg_addr  = addr_q;
   assign dbg_wdata = word_q;
   assign err_len   = err_len_q;

`ifdef IMEM_LOAD_VERIFY_EN
   assign err_verify = err_verify_q;
   assign err_addr   = err_addr_q;
`else
   assign err_verify = 1'b0;
   assign err_addr   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_loader_ctrl
//
// Directed bench for imem_loader_ctrl. For each load, the expected debug-port
// writes (address and little-endian packed word) are calculated from the
// byte list that is sent. A monitor then checks every write cycle against
// those expected writes. Directed checks cover handshake timing, reset and
// error cases. A small synchronous RAM model drives dbg_rdata and can corrupt
// one address for the read-back case.
// ---------------------------------------------------------------------------
module tb_imem_loader_ctrl;

   localparam int LEN_W = 16;
`ifdef IMEM_LOAD_VERIFY_EN
   localparam int DONE_LAT = 4;
`else
   localparam int DONE_LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len_words = '0;
   logic [7:0]       byte_in = '0;
   logic             byte_valid = 1'b0;
   logic             byte_ready;
   logic [31:0]      dbg_addr;
   logic [31:0]      dbg_wdata;
   logic [3:0]       dbg_we;
   logic [31:0]      dbg_rdata = '0;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic             err_len;
   logic             err_verify;
   logic [31:0]      err_addr;

   imem_loader_ctrl #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (4096),
      .LEN_W       (LEN_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len_words  (len_words),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_we     (dbg_we),
      .dbg_rdata  (dbg_rdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err_len    (err_len),
      .err_verify (err_verify),
      .err_addr   (err_addr)
   );

   always #5 clk = ~clk;

   int passCnt  = 0;
   int totalCnt = 0;
   int cycle    = 0;
   int writeCycle = 0;

   logic [7:0]  stim[$];
   logic [31:0] expAddrQ[$];
   logic [31:0] expDataQ[$];
   logic [31:0] logAddr[$];
   logic [31:0] logData[$];

   // Synchronous RAM behind the debug port, with an optional corrupted read.
   logic [31:0] ram [0:15];
   logic        corruptEn = 1'b0;

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = '0;
   end

   always @(posedge clk) begin
      if (dbg_we == 4'hF) ram[dbg_addr[5:2]] <= dbg_wdata;
      dbg_rdata <= (corruptEn && dbg_addr == 32'h4) ? 32'h0 : ram[dbg_addr[5:2]];
   end

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalCnt++;
      if (actual === expected) passCnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   // Expected writes for the first nWords words of the stimulus bytes.
   task automatic planWrites(input int nWords);
      for (int w = 0; w < nWords; w++) begin
         expAddrQ.push_back(32'(4 * w));
         expDataQ.push_back({stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
      end
   endtask

   // Each write cycle is compared with the next expected write.
   always @(negedge clk) begin
      if (rst_n && dbg_we != 4'h0) begin
         checkOutput("write_we", 32'(dbg_we), 32'hF);
         checkOutput("write_hold", 32'(cpu_hold), 32'h1);
         if (expAddrQ.size() == 0) begin
            totalCnt++;
            $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write",
                     dbg_addr, dbg_wdata);
         end else begin
            checkOutput("write_addr", dbg_addr, expAddrQ.pop_front());
            checkOutput("write_data", dbg_wdata, expDataQ.pop_front());
         end
         logAddr.push_back(dbg_addr);
         logData.push_back(dbg_wdata);
         writeCycle = cycle;
      end
   end

   // Pulse start with the given length. Returns on the negedge one cycle
   // after start was sampled.
   task automatic applyStimulus(input logic [LEN_W-1:0] len);
      @(negedge clk);
      len_words = len;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         totalCnt++;
         $display("[TB] FAIL byte_timeout: byte_ready 0 after %0d cycles, expected 1", n);
         byte_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 byte_valid = 1'b0;
      end
   endtask

   task automatic sendStim(input int first, input int count, input int gap);
      for (int i = first; i < first + count; i++) sendByte(stim[i], gap);
   endtask

   task automatic waitDone(input string name, input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(done), 32'h1);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_ctrl"},
                  32'({byte_ready, dbg_we, cpu_hold, busy, done, err_len, err_verify}), 32'h0);
      checkOutput({name, "_addr"}, dbg_addr, 32'h0);
      checkOutput({name, "_wdata"}, dbg_wdata, 32'h0);
      checkOutput({name, "_err_addr"}, err_addr, 32'h0);
   endtask

   task automatic clearLogs();
      logAddr.delete();
      logData.delete();
   endtask

   initial begin
      // Reset state
      #12 checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Two-word load with the expected writes and done timing
      $display("[TB] two-word load");
      clearLogs();
      stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      planWrites(2);
      applyStimulus(16'd2);
      checkOutput("t1_hold_after_start", 32'(cpu_hold), 32'h1);
      checkOutput("t1_busy_after_start", 32'(busy), 32'h1);
      sendStim(0, 8, 0);
      waitDone("t1_done", 40);
      checkOutput("t1_done_latency", 32'(cycle - writeCycle), 32'(DONE_LAT));
      checkOutput("t1_hold_at_fin", 32'(cpu_hold), 32'h0);
      checkOutput("t1_addr_held", dbg_addr, 32'h4);
      @(negedge clk);
      checkOutput("t1_done_single", 32'(done), 32'h0);
      checkOutput("t1_pending", 32'(expAddrQ.size()), 32'h0);
      checkOutput("t1_write_count", 32'(logData.size()), 32'h2);
      if (logData.size() == 2) begin
         checkOutput("t1_word0", logData[0], 32'h0000_0013);
         checkOutput("t1_word1", logData[1], 32'h0010_0093);
         checkOutput("t1_addr1", logAddr[1], 32'h0000_0004);
      end

      // Zero-length load
      $display("[TB] zero-length load");
      clearLogs();
      applyStimulus(16'd0);
      checkOutput("t2_done", 32'(done), 32'h1);
      checkOutput("t2_hold", 32'(cpu_hold), 32'h0);
      @(negedge clk);
      checkOutput("t2_done_single", 32'(done), 32'h0);
      checkOutput("t2_no_write", 32'(logData.size()), 32'h0);

      // Over-length load
      $display("[TB] over-length load");
      applyStimulus(16'd4097);
      checkOutput("t3_done", 32'(done), 32'h1);
      checkOutput("t3_err_len", 32'(err_len), 32'h1);
      checkOutput("t3_ready", 32'(byte_ready), 32'h0);
      checkOutput("t3_hold", 32'(cpu_hold), 32'h0);
      @(negedge clk);
      checkOutput("t3_err_sticky", 32'(err_len), 32'h1);
      checkOutput("t3_ready_later", 32'(byte_ready), 32'h0);
      checkOutput("t3_no_write", 32'(logData.size()), 32'h0);

      // Gappy stream with a start pulse ignored mid-load
      $display("[TB] toggled valid with stray start");
      clearLogs();
      stim = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      planWrites(1);
      applyStimulus(16'd1);
      checkOutput("t4_err_len_cleared", 32'(err_len), 32'h0);
      sendStim(0, 2, 1);
      applyStimulus(16'd3);
      sendStim(2, 2, 1);
      waitDone("t4_done", 40);
      repeat (5) @(negedge clk);
      checkOutput("t4_idle_after", 32'(busy), 32'h0);
      checkOutput("t4_write_count", 32'(logData.size()), 32'h1);
      if (logData.size() == 1) checkOutput("t4_word", logData[0], 32'hDEAD_BEEF);

      // Asynchronous reset mid-load, then a fresh load
      $display("[TB] reset mid-load");
      clearLogs();
      stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      planWrites(1);
      applyStimulus(16'd2);
      sendStim(0, 6, 0);
      @(negedge clk);
      checkOutput("t5_busy_before", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1 checkAllZero("t5_async");
      repeat (2) @(negedge clk);
      checkOutput("t5_pending", 32'(expAddrQ.size()), 32'h0);
      checkOutput("t5_write_count", 32'(logData.size()), 32'h1);
      rst_n = 1'b1;
      clearLogs();
      stim = '{8'h78, 8'h56, 8'h34, 8'h12};
      planWrites(1);
      applyStimulus(16'd1);
      sendStim(0, 4, 0);
      waitDone("t5_done", 40);
      checkOutput("t5_write_count2", 32'(logData.size()), 32'h1);
      if (logData.size() == 1) begin
         checkOutput("t5_word", logData[0], 32'h1234_5678);
         checkOutput("t5_addr", logAddr[0], 32'h0);
      end

`ifdef IMEM_LOAD_VERIFY_EN
      // Read-back mismatch at 0x4 aborts a three-word load
      $display("[TB] verify mismatch");
      clearLogs();
      corruptEn = 1'b1;
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      planWrites(2);
      applyStimulus(16'd3);
      sendStim(0, 8, 0);
      waitDone("t6_done", 40);
      checkOutput("t6_err_verify", 32'(err_verify), 32'h1);
      checkOutput("t6_err_addr", err_addr, 32'h4);
      repeat (10) @(negedge clk);
      checkOutput("t6_ready", 32'(byte_ready), 32'h0);
      checkOutput("t6_write_count", 32'(logData.size()), 32'h2);
      corruptEn = 1'b0;
`endif

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
